// File: rtl/fifo_rd_packer_pkg.sv
// rtl/fifo_rd_packer_pkg.sv - shared constants, clog2 helper and emit-kind type for the read-side packer
package fifo_rd_packer_pkg;

    localparam int DEF_DSIZE  = 8;
    localparam int DEF_ASIZE  = 4;
    localparam int DEF_NWORDS = 4;

    typedef enum logic [1:0] {
        EMIT_NONE  = 2'd0,
        EMIT_FULL  = 2'd1,
        EMIT_FLUSH = 2'd2
    } emit_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - output word register with valid/ready hold; reports when the slot is free
module stream_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [DW-1:0] tdata_i,
    input  logic [KW-1:0] tkeep_i,
    input  logic          tlast_i,
    output logic [DW-1:0] tdata_o,
    output logic [KW-1:0] tkeep_o,
    output logic          tlast_o,
    output logic          tvalid_o,
    input  logic          tready_i,
    output logic          free_o
);

    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    // load_i is only raised by the packer when free_o is high
    always_comb begin
        free_o  = !valid_q || tready_i;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = tdata_i;
            keep_d  = tkeep_i;
            last_d  = tlast_i;
            valid_d = 1'b1;
        end else if (tready_i) begin
            valid_d = 1'b0;
        end
    end

    assign tdata_o  = data_q;
    assign tkeep_o  = keep_q;
    assign tlast_o  = last_q;
    assign tvalid_o = valid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs NWORDS of them into one wide stream word, with flush
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE  = DEF_DSIZE,
    parameter int NWORDS = DEF_NWORDS,
    localparam int CW    = clog2(NWORDS)
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic [DSIZE-1:0]        rdata,
    input  logic                    rempty,
    output logic                    rinc,
    input  logic                    flush,
    output logic [DSIZE*NWORDS-1:0] out_data,
    output logic [NWORDS-1:0]       out_keep,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW:0]             fill
);

    localparam int CNTW = CW + 1;
    localparam logic [CNTW-1:0] LAST_LANE = CNTW'(NWORDS - 1);

    logic [NWORDS-1:0][DSIZE-1:0] asm_q, asm_d;
    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic                         flush_pend_q, flush_pend_d;

    logic                         out_free;
    logic                         pop;
    logic                         at_last;
    logic                         emit;
    logic                         flush_set;
    logic [CNTW-1:0]              eff_cnt;
    emit_e                        emit_kind;
    logic [NWORDS-1:0][DSIZE-1:0] word_data;
    logic [NWORDS-1:0]            word_keep;
    logic                         word_last;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        at_last = (cnt_q == LAST_LANE);
        // A pending flush freezes the partial word until the slot frees up
        pop     = !rempty && !(at_last && !out_free) && !(flush_pend_q && !out_free);
        eff_cnt = cnt_q + CNTW'(pop);

        emit_kind = EMIT_NONE;
        if (pop && at_last) begin
            emit_kind = EMIT_FULL;
        end else if (flush_pend_q && out_free) begin
            emit_kind = EMIT_FLUSH;
        end
        emit = (emit_kind != EMIT_NONE);

        // A flush arriving with a completing pop tags that word instead of queuing an empty one
        flush_set = flush && !emit && (eff_cnt != '0);
        word_last = flush_pend_q || flush;

        for (int i = 0; i < NWORDS; i++) begin
            word_keep[i] = (CNTW'(i) < eff_cnt);
            if (CNTW'(i) < cnt_q) begin
                word_data[i] = asm_q[i];
            end else if (pop && (CNTW'(i) == cnt_q)) begin
                word_data[i] = rdata;
            end else begin
                word_data[i] = '0;
            end
        end

        asm_d = asm_q;
        if (pop && !emit) begin
            asm_d[cnt_q[CW-1:0]] = rdata;
        end

        cnt_d        = emit ? '0 : eff_cnt;
        flush_pend_d = emit ? 1'b0 : (flush_pend_q || flush_set);
    end

    stream_out_reg #(
        .DW (DSIZE * NWORDS),
        .KW (NWORDS)
    ) u_out (
        .clk_i    (rclk),
        .rst_i    (rrst),
        .load_i   (emit),
        .tdata_i  (word_data),
        .tkeep_i  (word_keep),
        .tlast_i  (word_last),
        .tdata_o  (out_data),
        .tkeep_o  (out_keep),
        .tlast_o  (out_last),
        .tvalid_o (out_valid),
        .tready_i (out_ready),
        .free_o   (out_free)
    );

    assign rinc = pop && !rrst;
    assign fill = cnt_q;

endmodule
